edac_enc_sched: RTL and testbench
=================================

# edac_enc_sched

Scheduler that shares one combinational EDAC encoder (CRC-8 plus Hamming, 8-bit payload in, 32-bit codeword out) between two write requesters: requester 0 is the core store path and requester 1 is the IO path. It arbitrates round-robin and sequences the encoder through one registered encode cycle. It forwards each codeword with its address to the memory write port over a valid/ready handshake. It also owns the CRC polynomial configuration register and applies updates only between transactions.

## Interface
- POLY_RST, 8'h07, CRC polynomial loaded at reset
- AW, 16, address width
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  polynomial write strobe
- cfg_poly  in  8  new polynomial value
- req0_valid / req1_valid  in  1  requester has a write pending
- req0_data / req1_data  in  8  payload byte
- req0_addr / req1_addr  in  AW  target address
- req0_ready / req1_ready  out  1  request accepted this cycle
- enc_din  out  32  encoder data input; bits [31:8] are always 0
- enc_poly  out  8  encoder polynomial; always equals the active poly register
- enc_en  out  1  encoder enable; high only in ENCODE
- enc_dout  in  32  encoder codeword, combinational from enc_din/enc_poly
- mem_valid  out  1  codeword available
- mem_data  out  32  captured codeword
- mem_addr  out  AW  address of the codeword
- mem_src  out  1  id of the requester that produced the word
- mem_ready  in  1  memory port accepts the word
- busy  out  1  state != IDLE
- cnt0 / cnt1  out  16  completed transactions per requester; wrap modulo 2^16

## Operation
- FSM states:
  - IDLE -> ENCODE on a grant.
  - ENCODE -> OUT unconditionally.
  - OUT -> IDLE when mem_valid && mem_ready.
- Grant happens only in IDLE, only when no config is applied that cycle, and only when at least one reqN_valid is high.
  - Exactly one reqN_ready is high on a grant cycle. It is combinational from valid, state and the last pointer.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester that is not `last` wins.
  - `last` updates to the winner on every grant.
- On a grant, the block latches data, addr and src. In ENCODE it drives enc_din = {24'b0, data} and enc_en = 1. At the end of ENCODE it captures enc_dout into mem_data.
- In OUT, mem_valid is held high. mem_data, mem_addr and mem_src stay stable until the handshake completes. On the handshake, cnt[src] increments.
- Polynomial config:
  - cfg_we in IDLE: poly_reg <= cfg_poly next edge. No grant that cycle; config has priority over requests.
  - cfg_we outside IDLE: value goes to a pending register with a pend flag. A later cfg_we overwrites the pending value (last write wins).
  - When the FSM returns to IDLE with pend set, the first IDLE cycle applies the pending value and clears pend, with no grant. If cfg_we also arrives in that cycle, cfg_poly wins over the pending value.
  - A transaction always uses the polynomial that was active at its grant. poly_reg never changes during ENCODE or OUT.
- Reset mid-operation aborts the transaction. No output is completed, and counters are not incremented for it.

## Timing
- Reset values:
  - state = IDLE, last = 1 (so req0 wins first), poly_reg = POLY_RST, pend = 0.
  - mem_valid = 0; mem_data, mem_addr and mem_src = 0.
  - enc_en = 0, busy = 0, cnt0 = cnt1 = 0.
  - reqN_ready = 0 while rst_n is low.
- Latency:
  - Grant at cycle N, ENCODE at N+1, mem_valid high from N+2.
  - With mem_ready held high, one transaction takes 3 cycles: grant, ENCODE, OUT. The next grant is possible at N+3. Peak throughput is 1 word per 3 cycles.
- mem_ready low stalls indefinitely in OUT. No new grant occurs and requesters see ready = 0.
- Requesters must hold valid/data/addr until ready. The block samples them only on the grant cycle.
- cnt wraps from 16'hFFFF to 16'h0000 with no flag.

## Test plan
- Reset, then req0_valid with data 8'h00 and addr 16'h0010, mem_ready = 1:
  - req0_ready pulses at cycle 1.
  - enc_en is high at cycle 2 with enc_din = 0.
  - mem_valid is high at cycle 3 with mem_data = 32'h0, mem_addr = 16'h0010, mem_src = 0.
  - cnt0 = 1.
- Both requesters valid continuously, mem_ready = 1: grants alternate 0,1,0,1; after 8 transactions cnt0 = cnt1 = 4; each mem_data matches a golden encoder for its payload.
- mem_ready low for 5 cycles in OUT: mem_valid, data, addr and src stay stable; no reqN_ready pulses; on release, exactly one handshake occurs.
- cfg_we with 8'h1D during ENCODE: enc_poly stays 8'h07 through OUT. In the next IDLE cycle there is no grant and poly becomes 8'h1D. The following transaction encodes with 8'h1D.
- cfg_we and req1_valid in the same IDLE cycle: poly updates; req1_ready is 0 that cycle and 1 the next.
- Assert rst_n low during OUT: mem_valid drops immediately; state = IDLE; counters = 0; poly = POLY_RST.

Source files
------------

// File: rtl/edac_enc_sched.sv
// Round-robin scheduler sharing one external EDAC encoder between the core store
// path (req0) and the IO path (req1), with a deferred CRC polynomial config register.
module edac_enc_sched #(
    parameter logic [7:0] POLY_RST = 8'h07,
    parameter int         AW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [7:0]    cfg_poly,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    input  logic [AW-1:0] req1_addr,
    output logic          req1_ready,
    output logic [31:0]   enc_din,
    output logic [7:0]    enc_poly,
    output logic          enc_en,
    input  logic [31:0]   enc_dout,
    output logic          mem_valid,
    output logic [31:0]   mem_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_src,
    input  logic          mem_ready,
    output logic          busy,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENCODE = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    // Handshake: a word transfers on any rising edge where mem_valid && mem_ready;
    // a request transfers on any edge where reqN_valid && reqN_ready.
    logic [1:0]    state;
    logic          last;
    logic [7:0]    poly_reg;
    logic [7:0]    pend_poly;
    logic          pend;
    logic [7:0]    data_r;
    logic [AW-1:0] addr_r;
    logic          src_r;
    logic          cfg_apply;
    logic          grant;
    logic          win;
    logic          hs;

    always_comb begin
        cfg_apply  = (state == S_IDLE) && (cfg_we || pend);
        grant      = rst_n && (state == S_IDLE) && !cfg_apply && (req0_valid || req1_valid);
        // With both pending, the one that did not win last time goes next.
        win        = (req0_valid && req1_valid) ? ~last : req1_valid;
        req0_ready = grant && !win;
        req1_ready = grant && win;
        hs         = (state == S_OUT) && mem_ready;
    end

    assign enc_din   = (state == S_ENCODE) ? {24'b0, data_r} : 32'b0;
    assign enc_poly  = poly_reg;
    assign enc_en    = (state == S_ENCODE);
    assign mem_valid = (state == S_OUT);
    assign mem_addr  = addr_r;
    assign mem_src   = src_r;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            data_r   <= 8'd0;
            addr_r   <= '0;
            src_r    <= 1'b0;
            mem_data <= 32'd0;
            cnt0     <= 16'd0;
            cnt1     <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state  <= S_ENCODE;
                        last   <= win;
                        src_r  <= win;
                        data_r <= win ? req1_data : req0_data;
                        addr_r <= win ? req1_addr : req0_addr;
                    end
                end
                S_ENCODE: begin
                    mem_data <= enc_dout;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (hs) begin
                        state <= S_IDLE;
                        if (src_r) cnt1 <= cnt1 + 16'd1;
                        else       cnt0 <= cnt0 + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Polynomial only moves in IDLE, so an in-flight word keeps its grant-time poly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_reg  <= POLY_RST;
            pend_poly <= 8'd0;
            pend      <= 1'b0;
        end else if (state == S_IDLE) begin
            if (cfg_we) begin
                poly_reg <= cfg_poly;
                pend     <= 1'b0;
            end else if (pend) begin
                poly_reg <= pend_poly;
                pend     <= 1'b0;
            end
        end else if (cfg_we) begin
            pend_poly <= cfg_poly;
            pend      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_edac_enc_sched.sv
// Bench for edac_enc_sched: reference encoder on the enc_* port, scoreboard of
// expected {src, addr, codeword} checked at every memory handshake.
module tb_edac_enc_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_poly;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic [15:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic [31:0] enc_din;
    logic [7:0]  enc_poly;
    logic        enc_en;
    logic [31:0] enc_dout;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [15:0] mem_addr;
    logic        mem_src;
    logic        mem_ready;
    logic        busy;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    logic [48:0] exp_q[$];

    always #5 clk = ~clk;

    edac_enc_sched #(.POLY_RST(8'h07), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_poly(cfg_poly),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .enc_din(enc_din), .enc_poly(enc_poly), .enc_en(enc_en), .enc_dout(enc_dout),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_addr(mem_addr), .mem_src(mem_src),
        .mem_ready(mem_ready), .busy(busy), .cnt0(cnt0), .cnt1(cnt1), .dbg_state(dbg_state)
    );

    // Reference encoder: {12'b0, hamming[3:0], crc8[7:0], data[7:0]}, CRC MSB-first, init 0.
    function automatic logic [31:0] golden(input logic [7:0] d, input logic [7:0] poly);
        logic [7:0] c;
        logic [3:0] p;
        logic       fb;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
        end
        p = {^(d & 8'hF0), ^(d & 8'h8E), ^(d & 8'h6D), ^(d & 8'h5B)};
        return {12'h000, p, c, d};
    endfunction

    assign enc_dout = golden(enc_din[7:0], enc_poly);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_valid && mem_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
            else check("mem_word", {mem_src, mem_addr, mem_data}, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+2 of the grant cycle.
    task automatic wait_grant(output int w, output int cyc);
        bit got;
        got = 0;
        w   = -1;
        cyc = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = 1;
                w   = req1_ready ? 1 : 0;
                check("ready_onehot", {req0_ready, req1_ready} == 2'b11, 0);
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!got) check("grant_timeout", got, 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (exp_q.size() == 0 && !busy) done = 1;
            else step();
        end
        check("drain_timeout", done, 1);
    endtask

    int          w, cyc, exp_w, h0;
    int          exp_cnt0 = 0, exp_cnt1 = 0;
    logic [7:0]  model_poly;
    logic [7:0]  d4, d5;
    logic [48:0] e_stall;

    initial begin
        #200000;
        check("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_poly = 8'h00; mem_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h00; req0_addr = 16'h0010;
        req1_valid = 1'b0; req1_data = 8'h00; req1_addr = 16'h0000;
        model_poly = 8'h07;

        // Reset values, with a request already pending
        repeat (2) @(posedge clk);
        #2;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_enc_en", enc_en, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_poly", enc_poly, 8'h07);
        check("rst_state", dbg_state, 0);
        check("rst_mem_word", {mem_src, mem_addr, mem_data}, 0);

        // First transaction: grant, ENCODE, OUT
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        exp_q.push_back({1'b0, 16'h0010, golden(8'h00, model_poly)});
        exp_cnt0++;
        step();
        req0_valid = 1'b0;
        #1;
        check("t1_enc_en", enc_en, 1);
        check("t1_enc_din", enc_din, 0);
        check("t1_state", dbg_state, 1);
        step();
        #1;
        check("t1_mem_valid", mem_valid, 1);
        check("t1_mem_addr", mem_addr, 16'h0010);
        step();
        check("t1_cnt0", cnt0, 1);
        check("t1_idle", busy, 0);

        // Both requesters continuously valid: strict alternation, 3-cycle spacing
        exp_w = 1;
        req0_data = 8'($urandom_range(0, 255)); req0_addr = 16'($urandom_range(0, 65535));
        req1_data = 8'($urandom_range(0, 255)); req1_addr = 16'($urandom_range(0, 65535));
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_grant(w, cyc);
            check("rr_winner", w, exp_w);
            if (k > 0) check("rr_gap", cyc, 2);
            if (w == 1) begin
                exp_q.push_back({1'b1, req1_addr, golden(req1_data, model_poly)});
                exp_cnt1++;
            end else begin
                exp_q.push_back({1'b0, req0_addr, golden(req0_data, model_poly)});
                exp_cnt0++;
            end
            step();
            if (w == 1) begin
                req1_data = 8'($urandom_range(0, 255)); req1_addr = 16'($urandom_range(0, 65535));
            end else begin
                req0_data = 8'($urandom_range(0, 255)); req0_addr = 16'($urandom_range(0, 65535));
            end
            exp_w ^= 1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
        check("rr_cnt0", cnt0, exp_cnt0);
        check("rr_cnt1", cnt1, exp_cnt1);

        // Back-pressure in OUT for 5 cycles
        mem_ready = 1'b0;
        req0_data = 8'($urandom_range(0, 255)); req0_addr = 16'($urandom_range(0, 65535));
        req0_valid = 1'b1;
        wait_grant(w, cyc);
        check("stall_winner", w, 0);
        e_stall = {1'b0, req0_addr, golden(req0_data, model_poly)};
        exp_q.push_back(e_stall);
        exp_cnt0++;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'hA5; req1_data = 8'h5A;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_mem_valid", mem_valid, 1);
            check("stall_mem_word", {mem_src, mem_addr, mem_data}, e_stall);
            check("stall_no_ready", req0_ready | req1_ready, 0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        h0 = hs_cnt;
        mem_ready = 1'b1;
        step();
        check("stall_one_hs", hs_cnt - h0, 1);
        check("stall_valid_drop", mem_valid, 0);
        step();
        step();
        check("stall_still_one_hs", hs_cnt - h0, 1);
        check("stall_cnt0", cnt0, exp_cnt0);

        // Config write during ENCODE is deferred to the next IDLE cycle
        d4 = 8'($urandom_range(1, 255));
        d5 = 8'($urandom_range(1, 255));
        req0_data = d4; req0_addr = 16'h1234; req0_valid = 1'b1;
        wait_grant(w, cyc);
        check("cfg_winner", w, 0);
        exp_q.push_back({1'b0, 16'h1234, golden(d4, model_poly)});
        exp_cnt0++;
        step();
        req0_valid = 1'b0;
        cfg_we = 1'b1; cfg_poly = 8'h1D;
        req1_valid = 1'b1; req1_data = d5; req1_addr = 16'hBEEF;
        #1;
        check("cfg_enc_poly_encode", enc_poly, 8'h07);
        check("cfg_enc_din", enc_din, {24'b0, d4});
        step();
        cfg_we = 1'b0;
        #1;
        check("cfg_enc_poly_out", enc_poly, 8'h07);
        check("cfg_out_valid", mem_valid, 1);
        step();
        #1;
        check("cfg_apply_no_grant", req1_ready, 0);
        check("cfg_apply_idle", busy, 0);
        step();
        #1;
        check("cfg_poly_new", enc_poly, 8'h1D);
        check("cfg_next_grant", req1_ready, 1);
        model_poly = 8'h1D;
        exp_q.push_back({1'b1, 16'hBEEF, golden(d5, model_poly)});
        exp_cnt1++;
        step();
        req1_valid = 1'b0;
        wait_drain();

        // Config and request in the same IDLE cycle: config first
        cfg_we = 1'b1; cfg_poly = 8'h31;
        req1_valid = 1'b1; req1_data = 8'($urandom_range(0, 255)); req1_addr = 16'h0F0F;
        #1;
        check("cfgreq_no_grant", req1_ready, 0);
        step();
        cfg_we = 1'b0;
        #1;
        check("cfgreq_poly", enc_poly, 8'h31);
        check("cfgreq_grant", req1_ready, 1);
        model_poly = 8'h31;
        exp_q.push_back({1'b1, 16'h0F0F, golden(req1_data, model_poly)});
        exp_cnt1++;
        step();
        req1_valid = 1'b0;
        wait_drain();
        check("cfgreq_cnt1", cnt1, exp_cnt1);

        // Reset while stalled in OUT aborts the word
        mem_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h3C; req0_addr = 16'h0042;
        wait_grant(w, cyc);
        exp_q.push_back({1'b0, 16'h0042, golden(8'h3C, model_poly)});
        step();
        req0_valid = 1'b0;
        step();
        #1;
        check("abort_pre_valid", mem_valid, 1);
        h0 = hs_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_valid", mem_valid, 0);
        check("abort_state", dbg_state, 0);
        check("abort_cnt0", cnt0, 0);
        check("abort_cnt1", cnt1, 0);
        check("abort_poly", enc_poly, 8'h07);
        check("abort_busy", busy, 0);
        void'(exp_q.pop_back());
        model_poly = 8'h07;
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step();
        step();
        check("abort_no_hs", hs_cnt, h0);
        check("abort_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
